// File: rtl/rr_merge_fifo.sv
// rr_merge_fifo
//   Merges CHANNELS valid/ready input streams into one output stream.
//   A round-robin arbiter accepts at most one word per cycle and pushes it,
//   tagged with its source channel, into a DEPTH-entry FIFO. The FIFO head
//   drives the output stream.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   per-channel valid                       [CHANNELS]
//   in_data    packed data, channel i at [i*WIDTH +: WIDTH]
//   in_ready   per-channel ready, at most one bit high [CHANNELS]
//   out_valid  FIFO head valid
//   out_data   FIFO head data                          [WIDTH]
//   out_chan   source channel of the head word         [CW]
//   out_ready  consumer accepts the head
//   level      current FIFO occupancy, 0..DEPTH        [LW]
module rr_merge_fifo #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int LW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [CW-1:0]             out_chan,
    input  logic                      out_ready,
    output logic [LW-1:0]             level
);

    localparam int AW = $clog2(DEPTH);

    logic [CW-1:0]       rr_ptr;
    logic [CW+WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [LW-1:0]       count;

    logic                grant_valid;
    logic [CW-1:0]       grant_idx;
    logic                full;
    logic                push;
    logic                pop;
    int                  scan_idx;

    // Cyclic search starting at rr_ptr. The loop runs from the farthest
    // offset back to offset 0 so the closest valid channel is written last
    // and therefore wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            scan_idx = (int'(rr_ptr) + k) % CHANNELS;
            if (in_valid[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = CW'(scan_idx);
            end
        end
    end

    // No write-through when full, and nothing is accepted during reset, so
    // in_ready never looks at out_ready.
    assign full = (count == LW'(DEPTH));
    assign push = grant_valid && !full && !rst;
    assign pop  = out_valid && out_ready;

    always_comb begin
        in_ready = '0;
        if (push) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Storage and pointers. A stalled grant leaves rr_ptr untouched so the
    // waiting channel keeps its priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {grant_idx, in_data[int'(grant_idx)*WIDTH +: WIDTH]};
                wr_ptr      <= wr_ptr + 1'b1;
                if (int'(grant_idx) == CHANNELS - 1) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant_idx + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid            = (count != '0);
    assign {out_chan, out_data} = mem[rd_ptr];
    assign level                = count;

endmodule

// File: tb/tb_rr_merge_fifo.sv
// tb_rr_merge_fifo
//   Directed testbench for rr_merge_fifo with WIDTH=8, CHANNELS=4, DEPTH=4.
//   Inputs change one time unit after a rising edge; outputs are sampled
//   after the inputs settle, well clear of the next edge.
module tb_rr_merge_fifo;

    logic        clk;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_ready;
    logic [2:0]  level;

    int checks;
    int errors;

    rr_merge_fifo #(
        .WIDTH    (8),
        .CHANNELS (4),
        .DEPTH    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready),
        .level     (level)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Places one byte in a channel's lane of the packed input bus
    function automatic logic [31:0] chData(input int ch, input logic [7:0] v);
        return 32'(v) << (8 * ch);
    endfunction

    // Drive all inputs, then let combinational outputs settle
    task automatic applyStimulus(input logic r, input logic [3:0] v,
                                 input logic [31:0] d, input logic ordy);
        rst       = r;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    // Advance one clock and sample just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Full head snapshot: valid, channel, data and occupancy
    task automatic checkHead(input string tag, input logic v, input logic [1:0] ch,
                             input logic [7:0] d, input logic [2:0] lvl);
        checkOutput({tag, ".valid"}, 32'(out_valid), 32'(v));
        checkOutput({tag, ".chan"},  32'(out_chan),  32'(ch));
        checkOutput({tag, ".data"},  32'(out_data),  32'(d));
        checkOutput({tag, ".level"}, 32'(level),     32'(lvl));
    endtask

    logic [31:0] rrData;

    initial begin
        checks = 0;
        errors = 0;
        rrData = {8'h13, 8'h12, 8'h11, 8'h10};

        // Reset held for two cycles with every channel requesting
        applyStimulus(1'b1, 4'hF, rrData, 1'b0);
        tick();
        tick();
        checkOutput("reset.in_ready", 32'(in_ready), 32'h0);
        checkHead("reset", 1'b0, 2'd0, 8'h00, 3'd0);

        // Release: channel 0 holds the grant and pushes on the first edge
        applyStimulus(1'b0, 4'hF, rrData, 1'b0);
        checkOutput("release.in_ready", 32'(in_ready), 32'b0001);
        tick();
        checkHead("fill", 1'b1, 2'd0, 8'h10, 3'd1);

        // Round-robin: one push and one pop per cycle, channels in order
        applyStimulus(1'b0, 4'hF, rrData, 1'b1);
        checkOutput("rr.in_ready", 32'(in_ready), 32'b0010);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkHead($sformatf("rr%0d", i), 1'b1, 2'(i % 4), 8'(8'h10 + i % 4), 3'd1);
        end

        // Clean reset before the backpressure scenario
        applyStimulus(1'b1, 4'h0, 32'h0, 1'b0);
        tick();
        checkHead("reset2", 1'b0, 2'd0, 8'h00, 3'd0);

        // Full/backpressure: channel 2 alone fills the FIFO
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 4'b0100, chData(2, 8'(8'hA0 + j)), 1'b0);
            checkOutput($sformatf("fill%0d.in_ready", j), 32'(in_ready), 32'b0100);
            tick();
        end
        applyStimulus(1'b0, 4'b0100, chData(2, 8'hA4), 1'b0);
        checkOutput("full.in_ready", 32'(in_ready), 32'h0);
        checkHead("full", 1'b1, 2'd2, 8'hA0, 3'd4);

        // Drain: first pop frees a slot, the push lands one cycle later
        applyStimulus(1'b0, 4'b0100, chData(2, 8'hA4), 1'b1);
        tick();
        checkHead("drain0", 1'b1, 2'd2, 8'hA1, 3'd3);
        checkOutput("drain0.in_ready", 32'(in_ready), 32'b0100);
        tick();
        checkHead("drain1", 1'b1, 2'd2, 8'hA2, 3'd3);
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1);
        tick();
        checkHead("drain2", 1'b1, 2'd2, 8'hA3, 3'd2);
        tick();
        checkHead("drain3", 1'b1, 2'd2, 8'hA4, 3'd1);
        tick();
        checkOutput("drained.valid", 32'(out_valid), 32'h0);
        checkOutput("drained.level", 32'(level), 32'h0);

        // Simultaneous push/pop at level 2 (rr_ptr is 3, channel 1 wins)
        applyStimulus(1'b0, 4'b0010, chData(1, 8'h21), 1'b0);
        tick();
        applyStimulus(1'b0, 4'b0010, chData(1, 8'h22), 1'b0);
        tick();
        checkHead("pp.pre", 1'b1, 2'd1, 8'h21, 3'd2);
        applyStimulus(1'b0, 4'b0010, chData(1, 8'h55), 1'b1);
        tick();
        checkHead("pp.same", 1'b1, 2'd1, 8'h22, 3'd2);
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1);
        tick();
        checkHead("pp.new", 1'b1, 2'd1, 8'h55, 3'd1);
        tick();
        checkOutput("pp.empty", 32'(level), 32'h0);

        // Stalled priority: fill from channel 0 so rr_ptr ends at 1
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 4'b0001, chData(0, 8'(8'h40 + j)), 1'b0);
            tick();
        end
        applyStimulus(1'b0, 4'b1000, chData(3, 8'h77), 1'b0);
        for (int j = 0; j < 3; j++) begin
            tick();
            checkOutput($sformatf("stall%0d.in_ready", j), 32'(in_ready), 32'h0);
            checkOutput($sformatf("stall%0d.level", j), 32'(level), 32'd4);
        end
        applyStimulus(1'b0, 4'b1000, chData(3, 8'h77), 1'b1);
        tick();
        checkHead("stall.free", 1'b1, 2'd0, 8'h41, 3'd3);
        checkOutput("stall.free.in_ready", 32'(in_ready), 32'b1000);
        tick();
        checkHead("stall.push", 1'b1, 2'd0, 8'h42, 3'd3);
        // After channel 3 pushes, priority wraps around to channel 0
        applyStimulus(1'b0, 4'hF, {8'h63, 8'h62, 8'h61, 8'h60}, 1'b0);
        checkOutput("stall.rr_wrap", 32'(in_ready), 32'b0001);

        // Reset mid-stream with level 3 and pending requests
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b0);
        checkOutput("mid.level", 32'(level), 32'd3);
        applyStimulus(1'b1, 4'hF, {8'h63, 8'h62, 8'h61, 8'h60}, 1'b1);
        checkOutput("mid.rst.in_ready", 32'(in_ready), 32'h0);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 1'b1);
        checkHead("mid.after", 1'b0, 2'd0, 8'h00, 3'd0);
        tick();
        tick();
        checkOutput("mid.quiet.valid", 32'(out_valid), 32'h0);
        applyStimulus(1'b0, 4'b0100, chData(2, 8'h99), 1'b0);
        tick();
        checkHead("mid.fresh", 1'b1, 2'd2, 8'h99, 3'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
